// File: rtl/sd_fetch_pkg.sv
// Shared types for the SD block fetcher.
// Holds the FSM state encoding and the default block size.
package sd_fetch_pkg;

  localparam int unsigned BLOCK_BYTES_DEF = 512;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_REQ,
    S_ISSUE,
    S_RECV,
    S_DONE
  } state_e;

endpackage

// File: rtl/sd_block_fetcher.sv
// Streams consecutive SD blocks of a song into a downstream FIFO.
// One block read is issued per consumer fill request.
module sd_block_fetcher
  import sd_fetch_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES = BLOCK_BYTES_DEF,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_block,
  input  logic [15:0]       num_blocks,
  input  logic              fill_req,
  input  logic              sd_ready,
  output logic              sd_rd,
  output logic [ADDR_W-1:0] sd_addr,
  input  logic              sd_data_valid,
  input  logic [7:0]        sd_dout,
  input  logic              fifo_full,
  output logic              fifo_wr,
  output logic [7:0]        fifo_din,
  output logic              sd_done,
  output logic              song_done,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned CNT_W = $clog2(BLOCK_BYTES);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BLOCK_BYTES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [15:0]       remaining_q, remaining_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic              overflow_q, overflow_d;
  logic              fifo_wr_q, fifo_wr_d;
  logic [7:0]        fifo_din_q, fifo_din_d;
  logic              sd_done_q, sd_done_d;

  logic start_ok;
  logic byte_in;
  logic last_byte;

  assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE);
  assign byte_in   = (state_q == S_RECV) && sd_data_valid;
  assign last_byte = byte_in && (byte_cnt_q == LAST_BYTE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start)
            state_d = (num_blocks == 16'd0) ? S_DONE : S_WAIT_REQ;
        end
        S_WAIT_REQ: begin
          if (fill_req && sd_ready) state_d = S_ISSUE;
        end
        S_ISSUE: state_d = S_RECV;
        S_RECV: begin
          if (last_byte)
            state_d = (remaining_q == 16'd1) ? S_DONE : S_WAIT_REQ;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    sd_rd     = (state_q == S_ISSUE);
    sd_addr   = sd_rd ? cur_addr_q : '0;
    busy      = !(state_q == S_IDLE || state_q == S_DONE);
    song_done = (state_q == S_DONE);
  end

  // Dropped bytes still advance the count so block framing stays intact.
  always_comb begin
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    byte_cnt_d  = byte_cnt_q;
    overflow_d  = overflow_q;
    fifo_wr_d   = 1'b0;
    fifo_din_d  = fifo_din_q;
    sd_done_d   = 1'b0;
    if (abort) begin
      remaining_d = '0;
      byte_cnt_d  = '0;
    end else begin
      if (start_ok) begin
        cur_addr_d  = start_block;
        remaining_d = num_blocks;
        overflow_d  = 1'b0;
      end
      if (state_q == S_ISSUE) byte_cnt_d = '0;
      if (byte_in) begin
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
        if (fifo_full) begin
          overflow_d = 1'b1;
        end else begin
          fifo_wr_d  = 1'b1;
          fifo_din_d = sd_dout;
        end
      end
      if (last_byte) begin
        sd_done_d   = 1'b1;
        cur_addr_d  = cur_addr_q + ADDR_W'(1);
        remaining_d = remaining_q - 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr_q  <= '0;
      remaining_q <= '0;
      byte_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      fifo_wr_q   <= 1'b0;
      fifo_din_q  <= '0;
      sd_done_q   <= 1'b0;
    end else begin
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      byte_cnt_q  <= byte_cnt_d;
      overflow_q  <= overflow_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_din_q  <= fifo_din_d;
      sd_done_q   <= sd_done_d;
    end
  end

  assign fifo_wr  = fifo_wr_q;
  assign fifo_din = fifo_din_q;
  assign sd_done  = sd_done_q;
  assign overflow = overflow_q;

endmodule

// File: doc/sd_block_fetcher.md
SD_BLOCK_FETCHER -- requirements
Module: sd_block_fetcher

Interface
REQ-001 SHALL have parameter BLOCK_BYTES, default 512, bytes per SD block.
REQ-002 SHALL have parameter ADDR_W, default 32, SD block-address width.
REQ-003 SHALL have one clock, clk; reset is rst, asynchronous, active-high.
REQ-004 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  system clock
- rst  in  1  async active-high reset
- start  in  1  one-cycle pulse; begin fetching a song
- abort  in  1  one-cycle pulse; cancel the fetch, return to IDLE
- start_block  in  ADDR_W  first SD block of the song; sampled on an accepted start
- num_blocks  in  16  song length in blocks; sampled on an accepted start
- fill_req  in  1  level; the consumer requests another block
- sd_ready  in  1  SD controller idle
- sd_rd  out  1  one-cycle block read request
- sd_addr  out  ADDR_W  block address; valid while sd_rd is high
- sd_data_valid  in  1  sd_dout valid this cycle
- sd_dout  in  8  SD data byte
- fifo_full  in  1  downstream FIFO full
- fifo_wr  out  1  FIFO write strobe
- fifo_din  out  8  FIFO write data
- sd_done  out  1  one-cycle pulse; block complete
- song_done  out  1  level; all blocks of the song fetched
- busy  out  1  high in every state except IDLE and DONE
- overflow  out  1  sticky; a byte was dropped because the FIFO was full

Function
REQ-005 SHALL implement states IDLE, WAIT_REQ, ISSUE, RECV, DONE.
REQ-006 IDLE or DONE + start: latch cur_addr=start_block and remaining=num_blocks; clear overflow; go to DONE if num_blocks==0, else WAIT_REQ.
REQ-007 start SHALL be ignored in WAIT_REQ, ISSUE and RECV.
REQ-008 WAIT_REQ: when fill_req and sd_ready are both high, go to ISSUE; otherwise hold.
REQ-009 ISSUE: drive sd_rd=1 and sd_addr=cur_addr for exactly one cycle; clear byte_cnt; go to RECV.
REQ-010 RECV: each cycle with sd_data_valid high SHALL increment byte_cnt, whether or not the FIFO is full.
REQ-011 Registered write path: for a valid byte with fifo_full low in the same cycle, fifo_wr=1 and fifo_din=sd_dout SHALL appear exactly one cycle later.
REQ-012 For a valid byte with fifo_full high, the byte SHALL be dropped, fifo_wr SHALL stay 0 and overflow SHALL set.
REQ-013 When the byte with byte_cnt==BLOCK_BYTES-1 is received, all of the following SHALL occur one cycle later:
- sd_done pulses for one cycle;
- cur_addr increments by 1;
- remaining decrements by 1;
- next state is DONE if remaining becomes 0, else WAIT_REQ.
REQ-014 In the cycle of REQ-013, the last byte's fifo_wr SHALL coincide with sd_done.
REQ-015 sd_data_valid outside RECV SHALL be ignored: no write, no count.
REQ-016 DONE: song_done=1 and it holds until an accepted start or abort.
REQ-017 abort in any state SHALL force IDLE on the next edge and clear remaining, byte_cnt and song_done, with no sd_done pulse.
REQ-018 abort SHALL take priority over start and over block completion in the same cycle.
REQ-019 cur_addr SHALL wrap modulo 2^ADDR_W, and byte_cnt SHALL be $clog2(BLOCK_BYTES) bits wide.

Reset
REQ-020 On rst the block SHALL enter IDLE, and all of the following SHALL reset to 0: sd_rd, sd_addr, fifo_wr, fifo_din, sd_done, song_done, busy, overflow and all counters.
REQ-021 rst asserted mid-RECV SHALL take effect immediately (asynchronously) and abandon the partial block.

Structure
REQ-022 Package sd_fetch_pkg SHALL hold the state enum and the BLOCK_BYTES default.
REQ-023 The block SHALL be a single module with no sub-module; the byte counter and address counter are inline.

Verification
REQ-024 Bench SHALL cover the following scenarios:
- Single block: start, start_block=0x100, num_blocks=1, fill_req=1, sd_ready=1 -> one sd_rd with sd_addr=0x100; 512 bytes 0x00..0xFF repeating -> 512 fifo_wr in order, sd_done once, then song_done=1.
- Multi-block gating: num_blocks=3, fill_req held low after the first block -> stays in WAIT_REQ with no sd_rd; raise fill_req -> sd_addr=0x101, then 0x102; three sd_done pulses total.
- Backpressure: fifo_full high for bytes 10..12 -> those 3 bytes absent from the FIFO, overflow=1, sd_done still after 512 valids.
- Zero length and restart: num_blocks=0 -> DONE immediately, no sd_rd; start in DONE with num_blocks=1 -> overflow cleared, new fetch runs.
- Abort: abort after byte 200 of block 1 -> IDLE, busy=0, no sd_done; later sd_data_valid ignored; start and abort in the same cycle -> stays IDLE.
- Reset mid-RECV: rst pulse at byte 300 -> all outputs 0 asynchronously; a new start fetches cleanly from byte 0.
